// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar readout path.
//   state_t   : serializer FSM state encoding
//   sat_shift : unsigned right shift followed by saturation to adc_bits
package crossbar_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUANT = 2'd1,
        S_OUT   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Truncating shift, then clamp to the full-scale code of an adc_bits converter.
    // adc_bits must be below 32.
    function automatic logic [31:0] sat_shift(input logic [31:0] x,
                                              input int          shift,
                                              input int          adc_bits);
        logic [31:0] s;
        logic [31:0] lim;
        s   = x >> shift;
        lim = (32'd1 << adc_bits) - 32'd1;
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/readout_quantizer.sv
// Combinational quantizer for one column current word.
//   din  : unsigned column current, I_WIDTH bits
//   dout : din >> SHIFT, saturated to ADC_BITS
module readout_quantizer
    import crossbar_pkg::*;
#(
    parameter int I_WIDTH  = 16,
    parameter int ADC_BITS = 8,
    parameter int SHIFT    = 4
) (
    input  logic [I_WIDTH-1:0]  din,
    output logic [ADC_BITS-1:0] dout
);

    // sat_shift already clamps to ADC_BITS, so the cast only drops zero bits.
    assign dout = ADC_BITS'(sat_shift(32'(din), SHIFT, ADC_BITS));

endmodule

// File: rtl/column_readout_serializer.sv
// Snapshots all crossbar column currents on sample_i, then streams them out one
// quantized column per beat over a valid/ready interface.
//   clk, rst     : clock, async active-high reset
//   sample_i     : capture strobe (ignored and flagged as overrun while busy)
//   col_current  : flat column currents, column k at [k*I_WIDTH +: I_WIDTH]
//   out_ready    : consumer ready
//   ovr_clr      : clears the sticky overrun flag
//   out_valid, out_data, out_col, out_last : beat outputs
//   busy         : FSM not idle
//   frame_done   : one-cycle pulse after the last beat is accepted
//   overrun      : sticky, capture requested while busy
//
// state   | meaning
// S_IDLE  | waiting for sample_i
// S_QUANT | quantize snapshot[idx] into the output registers
// S_OUT   | hold beat until the consumer accepts it
// S_DONE  | emit frame_done, return to idle
module column_readout_serializer
    import crossbar_pkg::*;
#(
    parameter int N_COLS   = 8,
    parameter int I_WIDTH  = 16,
    parameter int ADC_BITS = 8,
    parameter int SHIFT    = 4,
    parameter int COL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample_i,
    input  logic [N_COLS*I_WIDTH-1:0] col_current,
    input  logic                      out_ready,
    input  logic                      ovr_clr,
    output logic                      out_valid,
    output logic [ADC_BITS-1:0]       out_data,
    output logic [COL_W-1:0]          out_col,
    output logic                      out_last,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun
);

    state_t             state;
    logic [COL_W-1:0]   idx;
    logic [I_WIDTH-1:0] snapshot [N_COLS];
    logic [ADC_BITS-1:0] q_data;

    readout_quantizer #(
        .I_WIDTH (I_WIDTH),
        .ADC_BITS(ADC_BITS),
        .SHIFT   (SHIFT)
    ) u_quant (
        .din (snapshot[idx]),
        .dout(q_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            for (int k = 0; k < N_COLS; k++) begin
                snapshot[k] <= '0;
            end
        end else begin
            frame_done <= 1'b0;

            // Set has priority over clear so a collision never loses an event.
            if (sample_i && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (sample_i) begin
                        for (int k = 0; k < N_COLS; k++) begin
                            snapshot[k] <= col_current[k*I_WIDTH +: I_WIDTH];
                        end
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_QUANT;
                    end
                end
                S_QUANT: begin
                    out_data  <= q_data;
                    out_col   <= idx;
                    out_last  <= (idx == COL_W'(N_COLS - 1));
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + COL_W'(1);
                            state <= S_QUANT;
                        end
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_column_readout_serializer.sv
module tb_column_readout_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sample_i = 1'b0;
    logic [127:0] col_current = '0;
    logic         out_ready = 1'b1;
    logic         ovr_clr = 1'b0;
    logic         out_valid;
    logic [7:0]   out_data;
    logic [2:0]   out_col;
    logic         out_last;
    logic         busy;
    logic         frame_done;
    logic         overrun;

    int vec  = 0;
    int miss = 0;

    typedef struct packed {
        logic [7:0][15:0] cur;
        logic [7:0][7:0]  exp;
    } frame_t;

    frame_t tbl [3];

    column_readout_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .sample_i   (sample_i),
        .col_current(col_current),
        .out_ready  (out_ready),
        .ovr_clr    (ovr_clr),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_col    (out_col),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Returns at the negedge where
    // frame_done is high.
    // ovr_mode: 0 none, 1 sample_i during ovr_beat, 2 sample_i + ovr_clr together.
    task automatic run_frame(input int f, input int stall_beat, input int stall_cycles,
                             input int ovr_beat, input int ovr_mode);
        int n;
        logic [7:0] hd;
        col_current = tbl[f].cur;
        sample_i    = 1'b1;
        @(negedge clk);
        sample_i = 1'b0;
        chk("capture_busy", 32'(busy), 32'd1);
        chk("capture_valid_low", 32'(out_valid), 32'd0);
        chk("frame_done_width", 32'(frame_done), 32'd0);
        for (int b = 0; b < 8; b++) begin
            n = 0;
            @(negedge clk);
            out_ready = (b == stall_beat) ? 1'b0 : 1'b1;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) begin
                chk("beat_timeout", 32'd1, 32'd0);
                return;
            end
            if (b == 0) chk("first_beat_latency", 32'(n), 32'd0);
            chk($sformatf("f%0d_b%0d_data", f, b), 32'(out_data), 32'(tbl[f].exp[b]));
            chk($sformatf("f%0d_b%0d_col", f, b), 32'(out_col), 32'(b));
            chk($sformatf("f%0d_b%0d_last", f, b), 32'(out_last), (b == 7) ? 32'd1 : 32'd0);
            if (b == stall_beat) begin
                hd = out_data;
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_data", 32'(out_data), 32'(hd));
                    chk("stall_col", 32'(out_col), 32'(b));
                end
                out_ready = 1'b1;
            end
            if (b == ovr_beat && ovr_mode != 0) begin
                col_current = ~col_current;
                sample_i    = 1'b1;
                ovr_clr     = (ovr_mode == 2);
                @(negedge clk);
                sample_i = 1'b0;
                ovr_clr  = 1'b0;
                chk("overrun_set", 32'(overrun), 32'd1);
            end
        end
        @(negedge clk);
        chk("done_wait_pulse", 32'(frame_done), 32'd0);
        chk("done_wait_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("frame_done_pulse", 32'(frame_done), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_col"}, 32'(out_col), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 8; k++) begin
            tbl[0].cur[k] = 16'(k * 32);
            tbl[0].exp[k] = 8'(k * 2);
        end
        tbl[1].cur = {16'h00F0, 16'h1234, 16'h0FF0, 16'h000F,
                      16'hFFFF, 16'h0010, 16'h0FFF, 16'h1000};
        tbl[1].exp = {8'h0F, 8'hFF, 8'hFF, 8'h00,
                      8'hFF, 8'h01, 8'hFF, 8'hFF};
        tbl[2].cur = {16'h0001, 16'h1000, 16'h00F0, 16'h0FFF,
                      16'h0A5A, 16'h07FF, 16'h0008, 16'h0100};
        tbl[2].exp = {8'h00, 8'hFF, 8'h0F, 8'hFF,
                      8'hA5, 8'h7F, 8'h00, 8'h10};

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_frame(0, -1, 0, -1, 0);
        run_frame(1, 2, 5, -1, 0);

        run_frame(2, -1, 0, 4, 1);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("overrun_cleared", 32'(overrun), 32'd0);

        run_frame(0, -1, 0, 4, 2);
        chk("overrun_set_wins", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("overrun_cleared2", 32'(overrun), 32'd0);

        // Reset while beat 3 is presented.
        col_current = tbl[2].cur;
        sample_i    = 1'b1;
        out_ready   = 1'b1;
        @(negedge clk);
        sample_i = 1'b0;
        n = 0;
        while (!(out_valid && out_col == 3'd3) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("reach_beat3", (n < 40) ? 32'd1 : 32'd0, 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", 32'(frame_done | out_valid | busy), 32'd0);
        end
        run_frame(1, -1, 0, -1, 0);

        // Back-to-back: second capture in the frame_done cycle.
        run_frame(2, -1, 0, -1, 0);
        run_frame(0, -1, 0, -1, 0);
        chk("b2b_no_overrun", 32'(overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
